// File: rtl/vdma_axi4_to_axi4s_core.sv
// Video DMA read core: fetches a 2-D frame buffer over an AXI4 read port and
// replays it as AXI4-Stream video (tuser = start of frame, tlast = end of line).
module vdma_axi4_to_axi4s_core #(
   parameter int AXI4_ID_WIDTH    = 6,
   parameter int AXI4_ADDR_WIDTH  = 32,
   parameter int AXI4_DATA_SIZE   = 2,
   parameter int AXI4_DATA_WIDTH  = (8 << AXI4_DATA_SIZE),
   parameter int AXI4_LEN_WIDTH   = 8,
   parameter int AXI4_QOS_WIDTH   = 4,
   parameter int AXI4S_USER_WIDTH = 1,
   parameter int AXI4S_DATA_WIDTH = AXI4_DATA_WIDTH,
   parameter int STRIDE_WIDTH     = 14,
   parameter int INDEX_WIDTH      = 8,
   parameter int H_WIDTH          = 12,
   parameter int V_WIDTH          = 12
) (
   input  logic                        aclk,
   input  logic                        aresetn,

   input  logic                        ctl_enable,
   input  logic                        ctl_update,
   output logic                        ctl_busy,
   output logic [INDEX_WIDTH-1:0]      ctl_index,
   output logic [1:0]                  dbg_state,

   input  logic [AXI4_ADDR_WIDTH-1:0]  param_addr,
   input  logic [STRIDE_WIDTH-1:0]     param_stride,
   input  logic [H_WIDTH-1:0]          param_width,
   input  logic [V_WIDTH-1:0]          param_height,
   input  logic [AXI4_LEN_WIDTH-1:0]   param_arlen,

   output logic [AXI4_ADDR_WIDTH-1:0]  monitor_addr,
   output logic [STRIDE_WIDTH-1:0]     monitor_stride,
   output logic [H_WIDTH-1:0]          monitor_width,
   output logic [V_WIDTH-1:0]          monitor_height,
   output logic [AXI4_LEN_WIDTH-1:0]   monitor_arlen,

   output logic [AXI4_ID_WIDTH-1:0]    m_axi4_arid,
   output logic [AXI4_ADDR_WIDTH-1:0]  m_axi4_araddr,
   output logic [1:0]                  m_axi4_arburst,
   output logic [3:0]                  m_axi4_arcache,
   output logic [AXI4_LEN_WIDTH-1:0]   m_axi4_arlen,
   output logic                        m_axi4_arlock,
   output logic [2:0]                  m_axi4_arprot,
   output logic [AXI4_QOS_WIDTH-1:0]   m_axi4_arqos,
   output logic [3:0]                  m_axi4_arregion,
   output logic [2:0]                  m_axi4_arsize,
   output logic                        m_axi4_arvalid,
   input  logic                        m_axi4_arready,

   input  logic [AXI4_ID_WIDTH-1:0]    m_axi4_rid,
   input  logic [AXI4_DATA_WIDTH-1:0]  m_axi4_rdata,
   input  logic [1:0]                  m_axi4_rresp,
   input  logic                        m_axi4_rlast,
   input  logic                        m_axi4_rvalid,
   output logic                        m_axi4_rready,

   output logic [AXI4S_USER_WIDTH-1:0] m_axi4s_tuser,
   output logic                        m_axi4s_tlast,
   output logic [AXI4S_DATA_WIDTH-1:0] m_axi4s_tdata,
   output logic                        m_axi4s_tvalid,
   input  logic                        m_axi4s_tready
);

   // Handshakes: a transfer happens on a rising edge where valid && ready; a
   // raised valid and its payload hold until that transfer completes.

   localparam int CW = ((H_WIDTH > AXI4_LEN_WIDTH) ? H_WIDTH : AXI4_LEN_WIDTH) + 1;

   typedef enum logic [1:0] {ST_IDLE, ST_START, ST_RUN} state_t;
   state_t state;

   logic [AXI4_ADDR_WIDTH-1:0] sh_addr;
   logic [STRIDE_WIDTH-1:0]    sh_stride;
   logic [H_WIDTH-1:0]         sh_width;
   logic [V_WIDTH-1:0]         sh_height;
   logic [AXI4_LEN_WIDTH-1:0]  sh_arlen;

   logic [AXI4_ADDR_WIDTH-1:0] line_base;
   logic [CW-1:0]              ar_hbeat;
   logic [V_WIDTH-1:0]         ar_line;
   logic                       r_run;
   logic                       r_first;
   logic [H_WIDTH-1:0]         r_h;
   logic [V_WIDTH-1:0]         r_v;

   logic [CW-1:0]              burst_beats;
   logic                       ar_line_end;
   logic                       at_boundary;
   logic                       r_accept;
   logic                       unused_r;

   assign burst_beats = CW'(sh_arlen) + CW'(1);
   assign ar_line_end = (ar_hbeat + burst_beats) == CW'(sh_width);
   assign at_boundary = (state == ST_IDLE) ||
                        ((state == ST_RUN) && !m_axi4_arvalid && !r_run);
   assign m_axi4_rready = r_run && (!m_axi4s_tvalid || m_axi4s_tready);
   assign r_accept      = m_axi4_rvalid && m_axi4_rready;
   assign unused_r      = ^{m_axi4_rid, m_axi4_rresp, m_axi4_rlast};

   assign dbg_state       = state;
   assign monitor_addr    = sh_addr;
   assign monitor_stride  = sh_stride;
   assign monitor_width   = sh_width;
   assign monitor_height  = sh_height;
   assign monitor_arlen   = sh_arlen;

   assign m_axi4_arid     = '0;
   assign m_axi4_arburst  = 2'b01;
   assign m_axi4_arcache  = 4'b0001;
   assign m_axi4_arlen    = sh_arlen;
   assign m_axi4_arlock   = 1'b0;
   assign m_axi4_arprot   = 3'b000;
   assign m_axi4_arqos    = '0;
   assign m_axi4_arregion = 4'b0000;
   assign m_axi4_arsize   = 3'(AXI4_DATA_SIZE);

   // Frame sequencer: parameters are latched only when a new frame is accepted.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state     <= ST_IDLE;
         ctl_busy  <= 1'b0;
         ctl_index <= '0;
      end else if (at_boundary) begin
         if (ctl_enable) begin
            state     <= ST_START;
            ctl_busy  <= 1'b1;
            ctl_index <= ctl_index + INDEX_WIDTH'(1);
            if (ctl_update) begin
               sh_addr   <= param_addr;
               sh_stride <= param_stride;
               sh_width  <= param_width;
               sh_height <= param_height;
               sh_arlen  <= param_arlen;
            end
         end else begin
            state    <= ST_IDLE;
            ctl_busy <= 1'b0;
         end
      end else if (state == ST_START) begin
         state <= ST_RUN;
      end
   end

   // AR engine: walks bursts along a line, then jumps to the next line base.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         m_axi4_arvalid <= 1'b0;
      end else if (state == ST_START) begin
         m_axi4_arvalid <= 1'b1;
         m_axi4_araddr  <= sh_addr;
         line_base      <= sh_addr;
         ar_hbeat       <= '0;
         ar_line        <= '0;
      end else if (m_axi4_arvalid && m_axi4_arready) begin
         if (ar_line_end) begin
            ar_hbeat      <= '0;
            m_axi4_araddr <= line_base + AXI4_ADDR_WIDTH'(sh_stride);
            line_base     <= line_base + AXI4_ADDR_WIDTH'(sh_stride);
            if (ar_line == sh_height - V_WIDTH'(1)) begin
               m_axi4_arvalid <= 1'b0;
            end else begin
               ar_line <= ar_line + V_WIDTH'(1);
            end
         end else begin
            ar_hbeat      <= ar_hbeat + burst_beats;
            m_axi4_araddr <= m_axi4_araddr + (AXI4_ADDR_WIDTH'(burst_beats) << AXI4_DATA_SIZE);
         end
      end
   end

   // R engine plus registered stream stage; framing comes from our own counters.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_run          <= 1'b0;
         m_axi4s_tvalid <= 1'b0;
      end else begin
         if (state == ST_START) begin
            r_run   <= 1'b1;
            r_first <= 1'b1;
            r_h     <= '0;
            r_v     <= '0;
         end
         if (r_accept) begin
            m_axi4s_tvalid <= 1'b1;
            m_axi4s_tdata  <= AXI4S_DATA_WIDTH'(m_axi4_rdata);
            m_axi4s_tuser  <= AXI4S_USER_WIDTH'(r_first);
            m_axi4s_tlast  <= (r_h == sh_width - H_WIDTH'(1));
            r_first        <= 1'b0;
            if (r_h == sh_width - H_WIDTH'(1)) begin
               r_h <= '0;
               if (r_v == sh_height - V_WIDTH'(1)) begin
                  r_run <= 1'b0;
               end else begin
                  r_v <= r_v + V_WIDTH'(1);
               end
            end else begin
               r_h <= r_h + H_WIDTH'(1);
            end
         end else if (m_axi4s_tready) begin
            m_axi4s_tvalid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_vdma_axi4_to_axi4s_core.sv
// Bench for vdma_axi4_to_axi4s_core: a memory-backed AXI4 read slave, a
// frame-level reference model feeding expected queues, and stream/AR monitors.
module tb_vdma_axi4_to_axi4s_core;

   localparam int AW = 32;
   localparam int DW = 32;

   // ---------------- clock / reset ----------------
   logic aclk = 1'b0;
   logic aresetn = 1'b0;
   int   cyc = 0;
   always #5 aclk = ~aclk;
   always @(posedge aclk) cyc++;

   // ---------------- DUT ----------------
   logic           ctl_enable, ctl_update, ctl_busy;
   logic [7:0]     ctl_index;
   logic [1:0]     dbg_state;
   logic [AW-1:0]  param_addr, monitor_addr;
   logic [13:0]    param_stride, monitor_stride;
   logic [11:0]    param_width, monitor_width;
   logic [11:0]    param_height, monitor_height;
   logic [7:0]     param_arlen, monitor_arlen;
   logic [5:0]     arid, rid;
   logic [AW-1:0]  araddr;
   logic [1:0]     arburst, rresp;
   logic [3:0]     arcache, arqos, arregion;
   logic [7:0]     arlen;
   logic           arlock, arvalid, arready;
   logic [2:0]     arprot, arsize;
   logic [DW-1:0]  rdata, tdata;
   logic           rlast, rvalid, rready;
   logic [0:0]     tuser;
   logic           tlast, tvalid, tready;

   vdma_axi4_to_axi4s_core dut (
      .aclk(aclk), .aresetn(aresetn),
      .ctl_enable(ctl_enable), .ctl_update(ctl_update), .ctl_busy(ctl_busy),
      .ctl_index(ctl_index), .dbg_state(dbg_state),
      .param_addr(param_addr), .param_stride(param_stride), .param_width(param_width),
      .param_height(param_height), .param_arlen(param_arlen),
      .monitor_addr(monitor_addr), .monitor_stride(monitor_stride),
      .monitor_width(monitor_width), .monitor_height(monitor_height),
      .monitor_arlen(monitor_arlen),
      .m_axi4_arid(arid), .m_axi4_araddr(araddr), .m_axi4_arburst(arburst),
      .m_axi4_arcache(arcache), .m_axi4_arlen(arlen), .m_axi4_arlock(arlock),
      .m_axi4_arprot(arprot), .m_axi4_arqos(arqos), .m_axi4_arregion(arregion),
      .m_axi4_arsize(arsize), .m_axi4_arvalid(arvalid), .m_axi4_arready(arready),
      .m_axi4_rid(rid), .m_axi4_rdata(rdata), .m_axi4_rresp(rresp),
      .m_axi4_rlast(rlast), .m_axi4_rvalid(rvalid), .m_axi4_rready(rready),
      .m_axi4s_tuser(tuser), .m_axi4s_tlast(tlast), .m_axi4s_tdata(tdata),
      .m_axi4s_tvalid(tvalid), .m_axi4s_tready(tready)
   );

   // ---------------- scoreboard state ----------------
   int n_checks = 0;
   int n_pass   = 0;
   logic [31:0] exp_ar_q[$];
   logic [33:0] exp_t_q[$];
   int          t_cyc_q[$];
   int          exp_index = 0;

   // reference shadow copy of the frame parameters
   logic [31:0] m_addr, m_stride;
   int          m_width, m_height, m_arlen;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic fail_note(input string name, input logic [63:0] act);
      n_checks++;
      $display("FAIL %s: got %0h, expected nothing (t=%0t)", name, act, $time);
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
   endfunction

   // Frame model: bursts per line = width/(arlen+1); lines are stride apart.
   task automatic push_frame(input logic [31:0] base, input logic [31:0] stride,
                             input int width, input int height, input int alen);
      int bl;
      logic [31:0] line;
      bl = alen + 1;
      for (int v = 0; v < height; v++) begin
         line = base + stride * v;
         for (int b = 0; b < width / bl; b++) exp_ar_q.push_back(line + 32'(b * bl * 4));
         for (int h = 0; h < width; h++)
            exp_t_q.push_back({(v == 0 && h == 0), (h == width - 1), mem_word(line + 32'(h * 4))});
      end
      exp_index++;
   endtask

   // ---------------- slave / stream sink driver ----------------
   logic [31:0] rb_addr_q[$];
   int          rb_len_q[$];
   int          rb_beat = 0;
   int          ar_hs_count = 0;
   int          tready_mode = 0, arready_mode = 0, rvalid_mode = 0, ar_block = 0;
   logic        r_hold = 1'b0;

   initial begin
      arready = 0; rvalid = 0; rdata = '0; rlast = 0; rid = '0; rresp = '0; tready = 0;
      forever begin
         @(negedge aclk);
         if (!aresetn) begin
            rb_addr_q.delete(); rb_len_q.delete();
            rb_beat = 0; r_hold = 0;
            arready = 0; rvalid = 0; tready = 0;
         end else begin
            if (ar_block > 0) begin
               arready = 0;
               ar_block--;
            end else if (arready_mode == 0) arready = 1;
            else arready = ($urandom_range(0, 2) != 0);
            case (tready_mode)
               0:       tready = 1;
               1:       tready = !tready;
               default: tready = ($urandom_range(0, 3) != 0);
            endcase
            if (!r_hold) begin
               if (rb_addr_q.size() > 0 && (rvalid_mode == 0 || $urandom_range(0, 2) != 0)) begin
                  rvalid = 1;
                  rdata  = mem_word(rb_addr_q[0] + 32'(rb_beat * 4));
                  rlast  = (rb_beat == rb_len_q[0] - 1);
                  rid    = 6'($urandom);
                  rresp  = 2'($urandom);
               end else rvalid = 0;
            end
            #1;
            if (arvalid && arready) begin
               rb_addr_q.push_back(araddr);
               rb_len_q.push_back(int'(arlen) + 1);
               ar_hs_count++;
            end
            r_hold = rvalid && !rready;
            if (rvalid && rready) begin
               rb_beat++;
               if (rb_beat == rb_len_q[0]) begin
                  void'(rb_addr_q.pop_front());
                  void'(rb_len_q.pop_front());
                  rb_beat = 0;
               end
            end
         end
      end
   end

   // ---------------- monitor ----------------
   logic        ar_stall = 0, t_stall = 0;
   logic [31:0] ar_prev;
   logic [34:0] t_prev, t_cur;
   logic [31:0] exp_a;
   logic [33:0] exp_t;

   initial begin
      forever begin
         @(negedge aclk);
         #2;
         if (!aresetn) begin
            ar_stall = 0;
            t_stall  = 0;
         end else begin
            if (ar_stall) check("ar_hold", {arvalid, araddr}, {1'b1, ar_prev});
            if (arvalid && arready) begin
               if (exp_ar_q.size() == 0) fail_note("ar_extra", araddr);
               else begin
                  exp_a = exp_ar_q.pop_front();
                  check("araddr", araddr, exp_a);
               end
            end
            ar_stall = arvalid && !arready;
            ar_prev  = araddr;

            t_cur = {tvalid, tuser, tlast, tdata};
            if (t_stall) check("t_hold", t_cur, t_prev);
            if (tvalid && !tready) check("rready_in_stall", rready, 1'b0);
            if (tvalid && tready) begin
               t_cyc_q.push_back(cyc);
               if (exp_t_q.size() == 0) fail_note("beat_extra", t_cur[33:0]);
               else begin
                  exp_t = exp_t_q.pop_front();
                  check("beat", t_cur[33:0], exp_t);
               end
            end
            t_stall = tvalid && !tready;
            t_prev  = t_cur;
         end
      end
   end

   // ---------------- stimulus tasks ----------------
   task automatic set_params(input logic [31:0] a, input int s, input int w, input int h, input int l);
      param_addr = a; param_stride = 14'(s); param_width = 12'(w);
      param_height = 12'(h); param_arlen = 8'(l);
   endtask

   task automatic start_frame(input logic upd);
      @(negedge aclk);
      ctl_update = upd;
      ctl_enable = 1;
      if (upd) begin
         m_addr = param_addr; m_stride = 32'(param_stride); m_width = int'(param_width);
         m_height = int'(param_height); m_arlen = int'(param_arlen);
      end
      push_frame(m_addr, m_stride, m_width, m_height, m_arlen);
   endtask

   task automatic wait_arvalid();
      int n = 0;
      while (!arvalid && n < 100) begin
         @(negedge aclk);
         n++;
      end
      if (!arvalid) fail_note("arvalid_timeout", n);
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (!(exp_ar_q.size() == 0 && exp_t_q.size() == 0 && !ctl_busy) && n < 3000) begin
         @(negedge aclk);
         n++;
      end
      if (n >= 3000) begin
         fail_note({name, "_timeout"}, exp_t_q.size());
         exp_ar_q.delete();
         exp_t_q.delete();
      end
      check({name, "_index"}, ctl_index, 8'(exp_index));
      repeat (5) @(negedge aclk);
      check({name, "_quiet"}, {ctl_busy, arvalid}, 2'b00);
   endtask

   task automatic one_frame(input logic upd, input string name);
      start_frame(upd);
      wait_arvalid();
      ctl_enable = 0;
      wait_done(name);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int hs0, n_a, bl, w, h;
      ctl_enable = 0; ctl_update = 0;
      set_params(32'h0, 0, 1, 1, 0);
      m_addr = 0; m_stride = 0; m_width = 1; m_height = 1; m_arlen = 0;
      repeat (4) @(negedge aclk);
      check("rst_busy", ctl_busy, 1'b0);
      check("rst_index", ctl_index, 8'd0);
      check("rst_valids", {arvalid, rready, tvalid}, 3'b000);
      aresetn = 1;
      @(negedge aclk);
      check("ar_const", {arid, arburst, arcache, arlock, arprot, arqos, arregion, arsize},
            {6'd0, 2'b01, 4'b0001, 1'b0, 3'd0, 4'd0, 4'd0, 3'd2});

      // basic frame, full throughput, enable-to-arvalid latency
      set_params(32'h1000, 32'h100, 4, 2, 1);
      t_cyc_q.delete();
      start_frame(1);
      @(negedge aclk);
      check("ar_latency_1", arvalid, 1'b0);
      @(negedge aclk);
      check("ar_latency_2", arvalid, 1'b1);
      ctl_enable = 0;
      wait_done("basic");
      check("basic_beats", t_cyc_q.size(), 8);
      if (t_cyc_q.size() == 8) check("basic_no_bubble", t_cyc_q[7] - t_cyc_q[0], 7);

      // tready toggling
      tready_mode = 1;
      one_frame(1, "toggle");

      // arready held low at frame start
      tready_mode = 2;
      set_params(32'h2000_0040, 32'h200, 6, 3, 2);
      ar_block = 12;
      one_frame(1, "ar_block");

      // mid-frame address change with update held: applies to the next frame only
      tready_mode = 2; arready_mode = 1; rvalid_mode = 1;
      set_params(32'h0003_0000, 32'h80, 8, 2, 3);
      hs0 = ar_hs_count;
      start_frame(1);
      n_a = (m_width / (m_arlen + 1)) * m_height;
      wait_arvalid();
      param_addr = 32'h0004_0100;
      m_addr = param_addr;
      push_frame(m_addr, m_stride, m_width, m_height, m_arlen);
      for (int n = 0; n < 2000 && ar_hs_count < hs0 + n_a + 1; n++) @(negedge aclk);
      ctl_enable = 0;
      wait_done("two_frames");
      check("two_frames_mon_addr", monitor_addr, 32'h0004_0100);

      // update low: new param_addr must be ignored
      param_addr = 32'h0777_0000;
      one_frame(0, "no_update");
      check("no_update_mon_addr", monitor_addr, 32'h0004_0100);

      // randomized frames, including address wrap and the minimal 1x1 frame
      for (int it = 0; it < 8; it++) begin
         tready_mode = $urandom_range(0, 2);
         arready_mode = $urandom_range(0, 1);
         rvalid_mode = $urandom_range(0, 1);
         if (it == 0) set_params(32'hFFFF_FFF8, 32'h10, 2, 2, 0);
         else if (it == 1) set_params(32'h0000_5000, 32'h4, 1, 1, 0);
         else begin
            bl = $urandom_range(1, 4);
            w  = bl * $urandom_range(1, 4);
            h  = $urandom_range(1, 3);
            set_params($urandom & 32'hFFFF_FFFC, $urandom_range(0, 4095) * 4, w, h, bl - 1);
         end
         one_frame(1, "rand");
      end

      // reset in the middle of a frame
      tready_mode = 2; arready_mode = 0; rvalid_mode = 1;
      set_params(32'h0010_0000, 32'h400, 8, 4, 1);
      hs0 = ar_hs_count;
      start_frame(1);
      for (int n = 0; n < 500 && ar_hs_count < hs0 + 3; n++) @(negedge aclk);
      @(negedge aclk);
      #2 aresetn = 0;
      @(negedge aclk);
      #1;
      check("mid_rst_valids", {arvalid, rready, tvalid}, 3'b000);
      check("mid_rst_busy", ctl_busy, 1'b0);
      check("mid_rst_index", ctl_index, 8'd0);
      exp_ar_q.delete();
      exp_t_q.delete();
      exp_index = 0;
      ctl_enable = 0;
      #2 aresetn = 1;
      tready_mode = 0; arready_mode = 0; rvalid_mode = 0;
      set_params(32'h0000_0800, 32'h40, 4, 1, 3);
      one_frame(1, "after_rst");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
